// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the 4-bit MIPS multicycle control slice.
//   - opcode encodings (R-type is any opcode with bit 3 set)
//   - control FSM state encoding (3-bit)
//   - instruction field offsets for the 16-bit instruction word
//   - helper functions used by the main control decoder
package mips_pkg;

    // Opcodes
    localparam logic [3:0] OP_LW   = 4'b0000;
    localparam logic [3:0] OP_SW   = 4'b0001;
    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_HALT = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;

    // Instruction field offsets (16-bit word)
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RS_LSB  = 10;
    localparam int unsigned RT_LSB  = 8;
    localparam int unsigned RD_LSB  = 6;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    function automatic logic is_rtype(input logic [3:0] opc);
        return opc[3];
    endfunction

    // Opcodes that decode to a real operation (everything else runs as NOP)
    function automatic logic is_legal(input logic [3:0] opc);
        return opc[3] || (opc == OP_LW) || (opc == OP_SW) ||
               (opc == OP_BEQ) || (opc == OP_ADDI) || (opc == OP_HALT);
    endfunction

    // ALU function presented during EXEC
    function automatic logic [3:0] exec_fun(input logic [3:0] opc);
        if (opc[3])
            return opc;
        else if (opc == OP_BEQ)
            return OP_SUB;
        else
            return OP_ADD;
    endfunction

    // Instructions whose ALU B operand is the sign-extended immediate
    function automatic logic uses_imm(input logic [3:0] opc);
        return (opc == OP_LW) || (opc == OP_SW) || (opc == OP_ADDI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles of an outstanding memory access.
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset
//   start   in  begin a new access window (count restarts at 0)
//   done    in  access completed, stop counting
//   expired out high during the MEM_TMO-th cycle of the window when
//               no completion has been seen yet
module mem_wait_timer #(
    parameter int unsigned MEM_TMO = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic done,
    output logic expired
);

    localparam int unsigned CW = $clog2(MEM_TMO + 1);

    logic [CW-1:0] count;
    logic          active;

    // count holds the number of already-elapsed cycles of the window
    assign expired = active && (count == CW'(MEM_TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            count  <= '0;
            active <= 1'b1;
        end else if (done || expired) begin
            count  <= '0;
            active <= 1'b0;
        end else if (active) begin
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_main_control.sv
// mips_main_control: multicycle main control FSM for the 4-bit MIPS datapath.
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, HALT is terminal.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   instr_valid/instr    instruction offered by instruction memory
//   instr_ready          controller is in FETCH and can accept
//   mem_ready            data memory access complete
//   zero                 ALU zero flag, sampled in EXEC
//   op_fun               ALU function to ALUControl
//   ir_write, pc_write, pc_src, alu_imm_sel, mem_read, mem_write,
//   reg_write, mem_to_reg datapath controls
//   halted, bus_err      sticky status flags
// All outputs are registers; each is updated on the edge that enters the
// state it belongs to, so a decision taken in a state (handshake, branch,
// mem_ready) becomes visible in the following cycle.
module mips_main_control
    import mips_pkg::*;
#(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned MEM_TMO = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               mem_ready,
    input  logic               zero,
    output logic [3:0]         op_fun,
    output logic               ir_write,
    output logic               alu_imm_sel,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               pc_write,
    output logic               pc_src,
    output logic               halted,
    output logic               bus_err
);

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         opc;
    logic               is_mem_op;
    logic               tmr_start;
    logic               tmr_done;
    logic               tmr_expired;

    // Register fields are consumed by the datapath, not by the controller
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[INSTR_W-5:0];

    assign opc       = ir[INSTR_W-1 -: 4];
    assign is_mem_op = (opc == OP_LW) || (opc == OP_SW);
    assign tmr_start = (state == S_EXEC) && is_mem_op;
    assign tmr_done  = (state == S_MEM) && mem_ready;

    mem_wait_timer #(
        .MEM_TMO (MEM_TMO)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (tmr_start),
        .done    (tmr_done),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            ir          <= '0;
            instr_ready <= 1'b0;
            op_fun      <= '0;
            ir_write    <= 1'b0;
            alu_imm_sel <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            reg_write   <= 1'b0;
            mem_to_reg  <= 1'b0;
            pc_write    <= 1'b0;
            pc_src      <= 1'b0;
            halted      <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            // single-cycle pulses
            ir_write  <= 1'b0;
            pc_write  <= 1'b0;
            pc_src    <= 1'b0;
            reg_write <= 1'b0;

            case (state)
                S_FETCH: begin
                    if (instr_ready && instr_valid) begin
                        ir          <= instr;
                        ir_write    <= 1'b1;
                        pc_write    <= 1'b1;
                        instr_ready <= 1'b0;
                        op_fun      <= instr[INSTR_W-1 -: 4];
                        state       <= S_DECODE;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end

                S_DECODE: begin
                    if (opc == OP_HALT) begin
                        op_fun <= '0;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (!is_legal(opc)) begin
                        op_fun      <= '0;
                        instr_ready <= 1'b1;
                        state       <= S_FETCH;
                    end else begin
                        op_fun      <= exec_fun(opc);
                        alu_imm_sel <= uses_imm(opc);
                        state       <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    alu_imm_sel <= 1'b0;
                    if (is_mem_op) begin
                        mem_read  <= (opc == OP_LW);
                        mem_write <= (opc == OP_SW);
                        state     <= S_MEM;
                    end else if (opc == OP_BEQ) begin
                        pc_write    <= zero;
                        pc_src      <= zero;
                        op_fun      <= '0;
                        instr_ready <= 1'b1;
                        state       <= S_FETCH;
                    end else begin
                        reg_write  <= 1'b1;
                        mem_to_reg <= 1'b0;
                        state      <= S_WB;
                    end
                end

                S_MEM: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (opc == OP_LW) begin
                            reg_write  <= 1'b1;
                            mem_to_reg <= 1'b1;
                            state      <= S_WB;
                        end else begin
                            op_fun      <= '0;
                            instr_ready <= 1'b1;
                            state       <= S_FETCH;
                        end
                    end else if (tmr_expired) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        op_fun    <= '0;
                        bus_err   <= 1'b1;
                        halted    <= 1'b1;
                        state     <= S_HALT;
                    end
                end

                S_WB: begin
                    mem_to_reg  <= 1'b0;
                    op_fun      <= '0;
                    instr_ready <= 1'b1;
                    state       <= S_FETCH;
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
